rv_dmem_responder: RTL and testbench

Data-memory responder for the MEM stage of RISC_V_pipeline; the core is the initiator and this block is the responder end of the load/store request/response interface.
- Accepts one load/store at a time over a valid/ready handshake.
- Holds the word-organised data RAM and inserts a configurable number of wait states.
- Returns read data with RISC-V byte/half sign/zero extension, or an error flag for misaligned or out-of-range accesses.

---
 rtl/rv_dmem_responder.sv | 200 ++++++++++++++++++++
 tb/tb_rv_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_dmem_responder.sv
// rtl/rv_dmem_responder.sv - MEM-stage data RAM responder with wait states and RISC-V load extension
// Optional build macro DMEM_ACCESS_CNT_EN adds saturating load/store/error handshake counters.
module rv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0] ld_count,
    output logic [15:0] st_count,
    output logic [15:0] err_count
`endif
);
    localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      wait_q, wait_d;
    logic            we_q, err_q;
    logic [2:0]      f3_q;
    logic [1:0]      lane_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            in_idle, accept, rsp_fire, enter_resp;
    logic [31:0]     req_off;
    logic [AW-1:0]   req_idx;
    logic            req_f3_ok, req_misal, req_range, req_err;
    logic [3:0]      wr_be;
    logic [31:0]     wr_data;
    logic            sel_we, sel_err;
    logic [2:0]      sel_f3;
    logic [1:0]      sel_lane;
    logic [AW-1:0]   sel_idx;
    logic [31:0]     rd_word, ld_ext;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;

    assign in_idle  = (state_q == S_IDLE);
    assign accept   = in_idle && req_valid;
    assign rsp_fire = (state_q == S_RESP) && rsp_ready;

    // Offset arithmetic wraps for addr < BASE_ADDR; the explicit compare keeps that case faulted.
    assign req_off = req_addr - BASE_ADDR;
    assign req_idx = req_off[AW+1:2];

    always_comb begin
        req_f3_ok = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                           : ((req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]));
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_range = (req_addr < BASE_ADDR) || (req_off >= SPAN);
        req_err   = !req_f3_ok || req_misal || req_range;
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && accept && req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_RESP;
                else                wait_d  = wait_q - 4'd1;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the load is read on the acceptance edge, so use the live request.
    assign sel_we     = in_idle ? req_we            : we_q;
    assign sel_err    = in_idle ? req_err           : err_q;
    assign sel_f3     = in_idle ? req_funct3        : f3_q;
    assign sel_lane   = in_idle ? req_addr[1:0]     : lane_q;
    assign sel_idx    = in_idle ? req_idx           : idx_q;
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    assign rd_word = mem_q[sel_idx];
    assign rd_byte = rd_word[{sel_lane, 3'b000} +: 8];
    assign rd_half = rd_word[{sel_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (sel_f3)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_ext = rd_word;
            3'b100:  ld_ext = {24'd0, rd_byte};
            3'b101:  ld_ext = {16'd0, rd_half};
            default: ld_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            idx_q   <= '0;
            rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                we_q   <= req_we;
                err_q  <= req_err;
                f3_q   <= req_funct3;
                lane_q <= req_addr[1:0];
                idx_q  <= req_idx;
            end
            if (enter_resp)    rdata_q <= (sel_we || sel_err) ? 32'd0 : ld_ext;
            else if (rsp_fire) rdata_q <= 32'd0;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = (state_q == S_RESP) && err_q;

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_count  <= 16'd0;
            st_count  <= 16'd0;
            err_count <= 16'd0;
        end else if (rsp_fire) begin
            if (err_q) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else if (we_q) begin
                if (st_count != 16'hFFFF) st_count <= st_count + 16'd1;
            end else begin
                if (ld_count != 16'hFFFF) ld_count <= ld_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rv_dmem_responder.sv
// tb/tb_rv_dmem_responder.sv - directed and randomized checks of rv_dmem_responder against a byte-level memory model
module tb_rv_dmem_responder;
    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam logic [31:0] LIMIT = BASE + 32'd1024;
    localparam int unsigned WS    = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] ref_mem [DEPTH];

    rv_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed view of the RAM; applies stores and computes load results.
    task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int unsigned nb, off, w, b;
        logic [31:0] v, mask;
        nb = 1 << int'(f3[1:0]);
        er = 1'b0;
        rd = 32'd0;
        if (we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
        if (a < BASE || a >= LIMIT) er = 1'b1;
        if (a % nb != 0) er = 1'b1;
        if (!er) begin
            off = a - BASE;
            w   = off / 4;
            b   = off % 4;
            if (we) begin
                for (int k = 0; k < int'(nb); k++) ref_mem[w][8*(b+k) +: 8] = wd[8*k +: 8];
            end else begin
                mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
                v = (ref_mem[w] >> (8*b)) & mask;
                if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~mask;
                rd = v;
            end
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag, output logic [31:0] rd);
        logic [31:0] erd;
        logic        eer;
        int          lat;
        ref_model(we, f3, a, wd, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, WS + 1);
        chk({tag, ".rdata"}, rsp_rdata, erd);
        chk({tag, ".err"}, {31'd0, rsp_err}, {31'd0, eer});
        rd = rsp_rdata;
        @(posedge clk); #1;
        chk({tag, ".idle_after"}, {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    task automatic reset_during_wait(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                     input string tag);
        logic [31:0] erd;
        logic        eer;
        logic        seen;
        ref_model(we, 3'b010, a, wd, erd, eer);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = 3'b010; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | rsp_valid;
            @(posedge clk); #1;
        end
        chk({tag, ".no_rsp"}, {31'd0, seen}, 32'd0);
        chk({tag, ".idle"}, {rsp_rdata[30:0], rsp_err, req_ready}, 32'd1);
    endtask

    logic [31:0] rd, erd, held;
    logic        eer, bad;
    int          lat;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr;
    int unsigned sel;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset.state", {rsp_rdata[29:0], rsp_err, rsp_valid, req_ready}, 32'd1);
        chk("reset.rdata", rsp_rdata, 32'd0);

        for (int w = 0; w < 8; w++) xact(1'b1, 3'b010, BASE + 32'(4*w), $urandom, "init", rd);
        xact(1'b1, 3'b010, LIMIT - 32'd4, 32'hCAFE_F00D, "sw_last", rd);
        xact(1'b0, 3'b010, LIMIT - 32'd4, 32'd0, "lw_last", rd);
        chk("lw_last.const", rd, 32'hCAFE_F00D);

        xact(1'b1, 3'b010, BASE, 32'hDEAD_BEEF, "sw0", rd);
        xact(1'b0, 3'b010, BASE, 32'd0, "lw0", rd);
        chk("lw0.const", rd, 32'hDEAD_BEEF);
        xact(1'b0, 3'b000, BASE + 32'd3, 32'd0, "lb3", rd);
        chk("lb3.const", rd, 32'hFFFF_FFDE);
        xact(1'b0, 3'b100, BASE + 32'd3, 32'd0, "lbu3", rd);
        chk("lbu3.const", rd, 32'h0000_00DE);
        xact(1'b0, 3'b001, BASE, 32'd0, "lh0", rd);
        chk("lh0.const", rd, 32'hFFFF_BEEF);
        xact(1'b0, 3'b101, BASE + 32'd2, 32'd0, "lhu2", rd);
        chk("lhu2.const", rd, 32'h0000_DEAD);
        xact(1'b1, 3'b000, BASE + 32'd1, 32'h0000_0055, "sb1", rd);
        xact(1'b0, 3'b010, BASE, 32'd0, "lw_sb", rd);
        chk("lw_sb.const", rd, 32'hDEAD_55EF);

        xact(1'b0, 3'b010, BASE + 32'd2, 32'd0, "lw_misal", rd);
        xact(1'b0, 3'b001, BASE + 32'd1, 32'd0, "lh_misal", rd);
        xact(1'b1, 3'b010, LIMIT, 32'h1234_5678, "sw_oob", rd);
        xact(1'b0, 3'b010, BASE - 32'd4, 32'd0, "lw_below", rd);
        xact(1'b0, 3'b011, BASE, 32'd0, "f3_011", rd);
        xact(1'b1, 3'b100, BASE, 32'hFFFF_FFFF, "st_f3_100", rd);
        xact(1'b0, 3'b010, BASE, 32'd0, "lw_after_faults", rd);
        chk("lw_after_faults.const", rd, 32'hDEAD_55EF);

        // Response back-pressure with a competing request that must not be taken.
        ref_model(1'b0, 3'b010, BASE, 32'd0, erd, eer);
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = BASE;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = BASE + 32'd4; req_wdata = 32'h0BAD_0BAD;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall.latency", lat, WS + 1);
        held = rsp_rdata;
        chk("stall.rdata", held, erd);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || req_ready || rsp_rdata !== held) bad = 1'b1;
        end
        chk("stall.stable", {31'd0, bad}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall.release", {30'd0, rsp_valid, req_ready}, 32'd1);
        xact(1'b0, 3'b010, BASE + 32'd4, 32'd0, "stall.no_store", rd);

        reset_during_wait(1'b0, BASE, 32'd0, "rst_lw");
        reset_during_wait(1'b1, BASE + 32'd8, 32'hA5A5_5A5A, "rst_sw");
        xact(1'b0, 3'b010, BASE + 32'd8, 32'd0, "rst_sw.committed", rd);
        chk("rst_sw.const", rd, 32'hA5A5_5A5A);

        for (int n = 0; n < 80; n++) begin
            rwe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) rf3 = 3'($urandom_range(0, 7));
            else if (rwe)                  rf3 = 3'($urandom_range(0, 2));
            else begin
                sel = $urandom_range(0, 4);
                rf3 = (sel > 2) ? 3'(sel + 1) : 3'(sel);
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      raddr = BASE - 32'($urandom_range(1, 8));
            else if (sel == 1) raddr = LIMIT + 32'($urandom_range(0, 7));
            else               raddr = BASE + 32'($urandom_range(0, 31));
            xact(rwe, rf3, raddr, $urandom, $sformatf("rnd%0d", n), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
